// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding, op encodings and default cycle counts for muldiv_ctrl
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_MULT_CYCLES = 32;
    localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// rtl/muldiv_ctrl_hilo_regs.sv - architectural HI/LO storage; operation result wins over MTHI/MTLO
module hilo_regs
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             res_we,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    input  logic             mt_hi_we,
    input  logic             mt_lo_we,
    input  logic [WIDTH-1:0] mt_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (res_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (mt_hi_we) hi <= mt_wdata;
            if (mt_lo_we) lo <= mt_wdata;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MULT/DIV sequencer owning HI/LO; MULDIV_PERF_CNT_EN adds busy-cycle and op counters
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_sel,
    input  logic             cancel,
    input  logic             mt_hi_we,
    input  logic             mt_lo_we,
    input  logic [WIDTH-1:0] mt_wdata,
    output logic             div_op,
    input  logic [WIDTH-1:0] div_hi_in,
    input  logic [WIDTH-1:0] div_lo_in,
    input  logic             divby0_in,
    output logic             mult_op,
    input  logic [WIDTH-1:0] mult_hi_in,
    input  logic [WIDTH-1:0] mult_lo_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
`ifdef MULDIV_PERF_CNT_EN
    output logic [31:0]      perf_busy_cycles,
    output logic [15:0]      perf_ops,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic             dz_q;
    logic             active;
    logic             res_we;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            dz_q  <= 1'b0;
        end else begin
            dz_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op_sel;
                        cnt   <= (op_sel == OP_DIV) ? DIV_LOAD : MULT_LOAD;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The counter still holds its load value only during the first RUN cycle.
                    if (cancel) begin
                        state <= IDLE;
                    end else if (op_q == OP_DIV && cnt == DIV_LOAD && divby0_in) begin
                        state <= IDLE;
                        dz_q  <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: state <= cancel ? IDLE : DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign active      = (state == RUN) || (state == CAPTURE);
    assign div_op      = active && (op_q == OP_DIV);
    assign mult_op     = active && (op_q == OP_MULT);
    assign busy        = active;
    assign done        = (state == DONE);
    assign div_by_zero = dz_q;

    // Divider reports quotient on its hi bus; MIPS puts quotient in LO and remainder in HI.
    assign res_we = (state == CAPTURE) && !cancel;
    assign res_hi = (op_q == OP_DIV) ? div_lo_in : mult_hi_in;
    assign res_lo = (op_q == OP_DIV) ? div_hi_in : mult_lo_in;

    hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clk      (clk),
        .reset_n  (reset_n),
        .res_we   (res_we),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .mt_hi_we (mt_hi_we && (state == IDLE)),
        .mt_lo_we (mt_lo_we && (state == IDLE)),
        .mt_wdata (mt_wdata),
        .hi       (hi),
        .lo       (lo)
    );

`ifdef MULDIV_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_busy_cycles <= '0;
            perf_ops         <= '0;
        end else begin
            if (busy && perf_busy_cycles != 32'hFFFF_FFFF)
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (done)
                perf_ops <= perf_ops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with behavioural multiplier/divider models
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op_sel = 1'b0;
    logic        cancel = 1'b0;
    logic        mt_hi_we = 1'b0;
    logic        mt_lo_we = 1'b0;
    logic [31:0] mt_wdata = '0;
    logic        div_op, mult_op, busy, done, div_by_zero;
    logic [31:0] div_hi_in, div_lo_in, mult_hi_in, mult_lo_in;
    logic        divby0_in;
    logic [31:0] hi, lo;
`ifdef MULDIV_PERF_CNT_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_ops;
`endif

    logic [31:0] opa = '0;
    logic [31:0] opb = 32'd1;

    typedef struct {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    muldiv_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op_sel      (op_sel),
        .cancel      (cancel),
        .mt_hi_we    (mt_hi_we),
        .mt_lo_we    (mt_lo_we),
        .mt_wdata    (mt_wdata),
        .div_op      (div_op),
        .div_hi_in   (div_hi_in),
        .div_lo_in   (div_lo_in),
        .divby0_in   (divby0_in),
        .mult_op     (mult_op),
        .mult_hi_in  (mult_hi_in),
        .mult_lo_in  (mult_lo_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
`ifdef MULDIV_PERF_CNT_EN
        .perf_busy_cycles (perf_busy_cycles),
        .perf_ops         (perf_ops),
`endif
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Behavioural datapaths: quotient on div_hi_in, remainder on div_lo_in.
    always_comb begin
        logic [63:0] prod;
        prod       = 64'(opa) * 64'(opb);
        mult_hi_in = prod[63:32];
        mult_lo_in = prod[31:0];
        divby0_in  = (opb == 32'd0);
        div_hi_in  = (opb == 32'd0) ? 32'd0 : opa / opb;
        div_lo_in  = (opb == 32'd0) ? 32'd0 : opa % opb;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && (done || div_by_zero)) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: done=%0b dz=%0b with nothing expected", done, div_by_zero);
            end else begin
                e = exp_q.pop_front();
                if (done === e.dz || div_by_zero !== e.dz || hi !== e.hi || lo !== e.lo) begin
                    errors++;
                    $display("FAIL sb_result: got done=%0b dz=%0b hi=0x%08h lo=0x%08h, expected dz=%0b hi=0x%08h lo=0x%08h",
                             done, div_by_zero, hi, lo, e.dz, e.hi, e.lo);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic dz, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.dz = dz; e.hi = h; e.lo = l;
        exp_q.push_back(e);
    endtask

    // Issues one op at edge 0 and observes until done/div_by_zero; edges are counted from the accept edge.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int done_edge, output int dz_edge, output int op_cnt, output int busy_cnt);
        opa = a; opb = b; op_sel = op; start = 1'b1;
        tick();
        start = 1'b0;
        done_edge = -1; dz_edge = -1; op_cnt = 0; busy_cnt = 0;
        for (int e = 0; e < 100; e++) begin
            if (div_op || mult_op) op_cnt++;
            if (busy) busy_cnt++;
            if (done) begin done_edge = e; break; end
            if (div_by_zero) begin dz_edge = e; break; end
            tick();
        end
    endtask

    initial begin
        int de, ze, oc, bc, nd;
        int d_edges[2];

        tick(); tick();
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_flags", {28'd0, busy, done, div_op, mult_op}, 32'd0);
        reset_n = 1'b1;
        tick();

        // DIV 100/7
        push(1'b0, 32'd2, 32'd14);
        do_op(1'b1, 32'd100, 32'd7, de, ze, oc, bc);
        check("div_done_edge", de, 33);
        check("div_op_cycles", oc, 33);
        check("div_busy_cycles", bc, 33);
        check("div_done_lines", {30'd0, busy, div_op}, 32'd0);
        tick(); tick();

        // MULT 0x10000 * 0x10000
        push(1'b0, 32'h1, 32'h0);
        do_op(1'b0, 32'h0001_0000, 32'h0001_0000, de, ze, oc, bc);
        check("mult_done_edge", de, 33);
        check("mult_op_cycles", oc, 33);
        tick(); tick();

        // Preload then divide by zero
        mt_wdata = 32'hAAAA_5555; mt_hi_we = 1'b1; mt_lo_we = 1'b1;
        tick();
        mt_hi_we = 1'b0; mt_lo_we = 1'b0;
        push(1'b1, 32'hAAAA_5555, 32'hAAAA_5555);
        do_op(1'b1, 32'd100, 32'd0, de, ze, oc, bc);
        check("dz_edge", ze, 1);
        check("dz_no_done", de, -1);
        tick();
        check("dz_pulse_len", div_by_zero, 1'b0);
        check("dz_idle", busy, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("dz_hi", hi, 32'hAAAA_5555);
        check("dz_lo", lo, 32'hAAAA_5555);

        // start held across two ops
        push(1'b0, 32'd2, 32'd14);
        push(1'b0, 32'd2, 32'd14);
        opa = 32'd100; opb = 32'd7; op_sel = 1'b1; start = 1'b1;
        tick();
        nd = 0;
        for (int e = 0; e < 100; e++) begin
            if (done) begin
                d_edges[nd] = e;
                nd++;
                if (nd == 2) begin start = 1'b0; break; end
            end
            tick();
        end
        start = 1'b0;
        check("held_done_count", nd, 2);
        check("held_first_edge", d_edges[0], 33);
        check("held_second_edge", d_edges[1], 68);
        tick(); tick();

        // start pulsed mid-RUN of a MULT is ignored
        push(1'b0, 32'h1, 32'hFFFF_FFFE);
        opa = 32'hFFFF_FFFF; opb = 32'd2; op_sel = 1'b0; start = 1'b1;
        tick();
        nd = 0;
        for (int e = 0; e < 80; e++) begin
            start = (e == 5);
            op_sel = (e == 5);
            if (done) nd++;
            tick();
        end
        start = 1'b0; op_sel = 1'b0;
        check("midrun_done_count", nd, 1);
        check("midrun_hi", hi, 32'h1);

        // cancel at edge 10 of a DIV
        opa = 32'd100; opb = 32'd7; op_sel = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 9; e++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_idle", {30'd0, busy, div_op}, 32'd0);
        nd = 0;
        for (int e = 0; e < 40; e++) begin
            if (done) nd++;
            tick();
        end
        check("cancel_no_done", nd, 0);
        check("cancel_hi", hi, 32'h1);
        check("cancel_lo", lo, 32'hFFFF_FFFE);

        // cancel beats the divide-by-zero abort
        opb = 32'd0; op_sel = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_dz_pulse", div_by_zero, 1'b0);
        check("cancel_dz_idle", busy, 1'b0);
        tick(); tick();

        // reset at edge 20 of a MULT
        opa = 32'd9; opb = 32'd9; op_sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 19; e++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        check("rst_mid_lines", {29'd0, busy, div_op, mult_op}, 32'd0);
        tick();

        // MTHI+MTLO in IDLE
        mt_wdata = 32'h1234_5678; mt_hi_we = 1'b1; mt_lo_we = 1'b1;
        tick();
        mt_hi_we = 1'b0; mt_lo_we = 1'b0;
        check("mt_hi", hi, 32'h1234_5678);
        check("mt_lo", lo, 32'h1234_5678);

        // mt write on the accept edge lands, mt during RUN is ignored, result overwrites
        push(1'b0, 32'd0, 32'd15);
        opa = 32'd3; opb = 32'd5; op_sel = 1'b0; start = 1'b1;
        mt_wdata = 32'hCAFE_F00D; mt_hi_we = 1'b1; mt_lo_we = 1'b1;
        tick();
        start = 1'b0; mt_hi_we = 1'b0; mt_lo_we = 1'b0;
        check("mt_start_hi", hi, 32'hCAFE_F00D);
        tick(); tick();
        mt_wdata = 32'hDEAD_BEEF; mt_hi_we = 1'b1; mt_lo_we = 1'b1;
        tick();
        mt_hi_we = 1'b0; mt_lo_we = 1'b0;
        check("mt_run_hi", hi, 32'hCAFE_F00D);
        check("mt_run_lo", lo, 32'hCAFE_F00D);
        nd = 0;
        for (int e = 0; e < 40; e++) begin
            if (done) nd++;
            tick();
        end
        check("mt_op_done_count", nd, 1);
        check("mt_op_lo", lo, 32'd15);

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
